stream_merge_2to1: RTL and testbench

Two-channel 8-bit byte-stream merger that sits directly upstream of the 8-bit 2:1 data mux. It arbitrates between producers A and B with valid/ready handshakes and drives the mux select: `sel`=1 selects A, `sel`=0 selects B. It then registers the selected byte into a one-entry output stage with its own valid/ready handshake. Arbitration is round-robin with a bounded burst, so one busy producer cannot starve the other.

---
 rtl/stream_merge_2to1_pkg.sv | 14 +
 rtl/stream_merge_2to1_rr_arb2.sv | 73 +++++++
 rtl/stream_merge_2to1.sv | 78 +++++++
 tb/tb_stream_merge_2to1.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_merge_2to1_pkg.sv
// Shared encodings for the two-channel byte-stream merger and its arbiter.
package stream_merge_2to1_pkg;

    localparam int DATA_W = 8;

    localparam logic CH_A = 1'b1;
    localparam logic CH_B = 1'b0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/stream_merge_2to1_rr_arb2.sv
// Two-way arbiter with round-robin tie breaking and a bounded burst length.
// Build with MERGE_FIXED_PRIO_EN defined for fixed A-over-B priority.
module rr_arb2
    import stream_merge_2to1_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    input  logic can_take,
    output logic grant,
    output logic grant_valid,
    output logic owner
);

    assign grant_valid = can_take && (a_valid || b_valid);

`ifdef MERGE_FIXED_PRIO_EN
    always_comb begin
        grant = owner;
        if (a_valid) begin
            grant = CH_A;
        end else if (b_valid) begin
            grant = CH_B;
        end
    end

    // owner only remembers the last grant so sel can hold it while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= CH_B;
        end else if (grant_valid) begin
            owner <= grant;
        end
    end
`else
    localparam logic [2:0] CNT_MAX = 3'(BURST_MAX);

    logic [2:0] burst_cnt;
    logic       in_burst;

    assign in_burst = (burst_cnt != 3'd0) && (burst_cnt < CNT_MAX);

    always_comb begin
        grant = owner;
        if (a_valid && b_valid) begin
            grant = in_burst ? owner : !owner;
        end else if (a_valid) begin
            grant = CH_A;
        end else if (b_valid) begin
            grant = CH_B;
        end
    end

    // The count saturates, so a lone requester keeps winning but loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= CH_B;
            burst_cnt <= 3'd0;
        end else if (grant_valid) begin
            if ((grant == owner) && (burst_cnt != 3'd0)) begin
                burst_cnt <= (burst_cnt >= CNT_MAX) ? CNT_MAX : burst_cnt + 3'd1;
            end else begin
                owner     <= grant;
                burst_cnt <= 3'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/stream_merge_2to1.sv
// Merges two valid/ready byte streams into one registered output stage.
// Define MERGE_FIXED_PRIO_EN for fixed A priority instead of round-robin.
module stream_merge_2to1
    import stream_merge_2to1_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output out_state_t        out_state
);

    // Handshakes: a byte moves on any edge where its valid and ready are both
    // high; a source holds data stable while valid && !ready.
    out_state_t state_q;
    out_state_t state_d;
    logic       can_take;
    logic       grant;
    logic       grant_valid;
    logic       owner;

    assign out_valid = (state_q == ST_FULL);
    assign out_state = state_q;
    assign can_take  = !out_valid || out_ready;

    rr_arb2 #(
        .BURST_MAX(BURST_MAX)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .can_take   (can_take),
        .grant      (grant),
        .grant_valid(grant_valid),
        .owner      (owner)
    );

    assign sel     = grant_valid ? grant : owner;
    assign a_ready = grant_valid && (grant == CH_A);
    assign b_ready = grant_valid && (grant == CH_B);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant_valid) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !grant_valid) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (grant_valid) begin
            out_data <= (sel == CH_A) ? a_data : b_data;
        end
    end

endmodule

// File: tb/tb_stream_merge_2to1.sv
// Directed bench for stream_merge_2to1: reset, streaming, ties, burst cap,
// backpressure. Expected values follow MERGE_FIXED_PRIO_EN when it is defined.
module tb_stream_merge_2to1;
    import stream_merge_2to1_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    out_state_t out_state;

    int vectors    = 0;
    int miscompares = 0;

    stream_merge_2to1 #(.BURST_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tie_exp [10];
        logic [7:0] bp_exp [4];
        logic [7:0] cap_exp;
        logic       cap_b_ready;
        logic       cap_sel;
        logic [7:0] drop_exp;
        logic       ha;
        logic       hb;
        int         ai;
        int         bi;

`ifdef MERGE_FIXED_PRIO_EN
        tie_exp     = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        cap_exp     = 8'h16;
        cap_b_ready = 1'b0;
        cap_sel     = 1'b1;
        bp_exp      = '{8'h17, 8'h18, 8'h19, 8'h1A};
        drop_exp    = 8'h20;
`else
        tie_exp     = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA4, 8'hA5};
        cap_exp     = 8'h20;
        cap_b_ready = 1'b1;
        cap_sel     = 1'b0;
        bp_exp      = '{8'h21, 8'h22, 8'h23, 8'h16};
        drop_exp    = 8'h24;
`endif

        // Reset state
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        a_data = 8'h00; b_data = 8'h00;
        #12;
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_sel", {7'b0, sel}, 8'h00);
        chk("rst_a_ready_idle", {7'b0, a_ready}, 8'h00);
        rst = 1'b0;
        tick();

        // Single channel A streams 01,02,03
        a_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_data = 8'(i);
            #4;
            chk("single_a_ready", {7'b0, a_ready}, 8'h01);
            chk("single_sel", {7'b0, sel}, 8'h01);
            tick();
            chk("single_data", out_data, 8'(i));
            chk("single_valid", {7'b0, out_valid}, 8'h01);
        end

        // Asynchronous reset with a byte held
        a_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("hold_before_rst", out_data, 8'h03);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_sel", {7'b0, sel}, 8'h00);
        #1;
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("post_rst_idle", {7'b0, out_valid}, 8'h00);

        // Tie: both channels always valid
        ai = 0; bi = 0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_data = 8'hA0 + 8'(ai);
            b_data = 8'hB0 + 8'(bi);
            #4;
            ha = a_ready; hb = b_ready;
            chk("tie_one_ready", {7'b0, ha ^ hb}, 8'h01);
            if (i == 0) chk("tie_first_sel_a", {7'b0, sel}, 8'h01);
            tick();
            chk("tie_data", out_data, tie_exp[i]);
            if (ha) ai++;
            if (hb) bi++;
        end

        // Burst cap: A alone for six transfers, then B joins
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        ai = 0; bi = 0;
        a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 8'h10 + 8'(ai);
            #4;
            ha = a_ready;
            tick();
            chk("cap_a_data", out_data, 8'h10 + 8'(i));
            if (ha) ai++;
        end
        b_valid = 1'b1;
        a_data = 8'h10 + 8'(ai);
        b_data = 8'h20 + 8'(bi);
        #4;
        ha = a_ready; hb = b_ready;
        chk("cap_b_ready", {7'b0, hb}, {7'b0, cap_b_ready});
        chk("cap_sel", {7'b0, sel}, {7'b0, cap_sel});
        tick();
        chk("cap_data", out_data, cap_exp);
        if (ha) ai++;
        if (hb) bi++;

        // Backpressure for three cycles, then resume
        out_ready = 1'b0;
        a_data = 8'h10 + 8'(ai);
        b_data = 8'h20 + 8'(bi);
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("bp_a_ready", {7'b0, a_ready}, 8'h00);
            chk("bp_b_ready", {7'b0, b_ready}, 8'h00);
            tick();
            chk("bp_hold_data", out_data, cap_exp);
            chk("bp_hold_valid", {7'b0, out_valid}, 8'h01);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'h10 + 8'(ai);
            b_data = 8'h20 + 8'(bi);
            #4;
            ha = a_ready; hb = b_ready;
            tick();
            chk("bp_resume_data", out_data, bp_exp[i]);
            if (ha) ai++;
            if (hb) bi++;
        end

        // A drops: B is granted in the same cycle
        a_valid = 1'b0;
        b_data = 8'h20 + 8'(bi);
        #4;
        chk("drop_b_ready", {7'b0, b_ready}, 8'h01);
        chk("drop_sel", {7'b0, sel}, 8'h00);
        tick();
        chk("drop_data", out_data, drop_exp);
        b_valid = 1'b0;
        tick();
        chk("drain_valid", {7'b0, out_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
